mb_pp_accumulator: RTL and testbench

//  Sequential summation stage behind the modified-Booth partial-product generators and correction

---
 rtl/mb_pp_accumulator_pkg.sv | 21 ++
 rtl/mb_pp_shift_add.sv | 19 +
 rtl/mb_pp_accumulator.sv | 109 ++++++++++
 tb/tb_mb_pp_accumulator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mb_pp_accumulator_pkg.sv
// Shared definitions for the modified-Booth multiplier slice: default sizes,
// FSM state encodings and a small sizing helper.
package mb_pp_accumulator_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_PP  = DEF_WIDTH / 2;
    localparam int DEF_PP_W  = DEF_WIDTH + 1;
    localparam int DEF_P_W   = 2 * DEF_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Index counters need at least one bit even when only one PP exists.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mb_pp_shift_add.sv
// Combinational adder step: acc + (zero-extended pp shifted by two bits per index),
// truncated to the accumulator width.
module mb_pp_shift_add #(
    parameter int P_W   = 16,
    parameter int PP_W  = 9,
    parameter int IDX_W = 2
) (
    input  logic [P_W-1:0]   acc_i,
    input  logic [PP_W-1:0]  pp_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [P_W-1:0]   sum_o
);

    logic [P_W-1:0] ppExt;

    assign ppExt = P_W'(pp_i);
    assign sum_o = acc_i + (ppExt << {idx_i, 1'b0});

endmodule

// File: rtl/mb_pp_accumulator.sv
// Sequential summation of radix-4 Booth partial products through one shared adder,
// with valid/ready handshakes on both the transaction input and the product output.
module mb_pp_accumulator
    import mb_pp_accumulator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_PP  = WIDTH / 2,
    parameter int PP_W  = WIDTH + 1,
    parameter int P_W   = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_PP*PP_W-1:0] pp_bus,
    input  logic [P_W-1:0]       cor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P_W-1:0]       product,
    output logic                 busy
);

    localparam int IDX_W = idxWidth(N_PP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PP - 1);

    state_e                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [N_PP*PP_W-1:0]  ppReg_q;
    logic [P_W-1:0]        acc_q;
    logic [P_W-1:0]        acc_d;
    logic [P_W-1:0]        product_q;
    logic                  inReady_q;
    logic                  outValid_q;
    logic                  busy_q;
    logic [PP_W-1:0]       ppSel;

    // Selecting from the captured copy keeps the mux on defined data whatever pp_bus does.
    assign ppSel = ppReg_q[int'(idx_q)*PP_W +: PP_W];

    mb_pp_shift_add #(
        .P_W   (P_W),
        .PP_W  (PP_W),
        .IDX_W (IDX_W)
    ) u_shift_add (
        .acc_i (acc_q),
        .pp_i  (ppSel),
        .idx_i (idx_q),
        .sum_o (acc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            ppReg_q    <= '0;
            acc_q      <= '0;
            product_q  <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && inReady_q) begin
                        ppReg_q   <= pp_bus;
                        acc_q     <= cor;
                        idx_q     <= '0;
                        state_q   <= S_ACC;
                        inReady_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                S_ACC: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q      <= '0;
                        state_q    <= S_DONE;
                        outValid_q <= 1'b1;
                        product_q  <= acc_d;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    // Returning to IDLE first means a new transaction is never taken in DONE.
                    if (out_ready) begin
                        state_q    <= S_IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    idx_q      <= '0;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mb_pp_accumulator.sv
// Directed self-checking bench for mb_pp_accumulator with hand-computed products
// and a Booth-encoded 8x8 stream checked against plain multiplication.
module tb_mb_pp_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [35:0] pp_bus = '0;
    logic [15:0] cor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mb_pp_accumulator #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp_bus    (pp_bus),
        .cor       (cor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] p0, input logic [8:0] p1, input logic [8:0] p2,
                                 input logic [8:0] p3, input logic [15:0] c, input logic v);
        pp_bus   = {p3, p2, p1, p0};
        cor      = c;
        in_valid = v;
    endtask

    // Bounded wait; n counts edges after the accept edge until out_valid is seen.
    task automatic waitOutValid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Radix-4 Booth generator with a sign-correction word, used as the stimulus source.
    task automatic boothGen(input logic signed [7:0] a, input logic signed [7:0] b,
                            output logic [35:0] pps, output logic [15:0] c);
        logic [8:0] bx;
        int d;
        int v;
        int corInt;
        bx = {b, 1'b0};
        corInt = 0;
        pps = '0;
        for (int i = 0; i < 4; i++) begin
            d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            v = d * int'(a);
            pps[i*9 +: 9] = v[8:0];
            if (v < 0) corInt = corInt - (1 << (9 + 2*i));
        end
        c = corInt[15:0];
    endtask

    // With out_ready high, out_valid is seen after 4 edges, so the consumer takes it on the 5th.
    task automatic runTxn(input string tag, input logic [8:0] p0, input logic [8:0] p1,
                          input logic [8:0] p2, input logic [8:0] p3, input logic [15:0] c,
                          input logic [15:0] expected);
        int n;
        applyStimulus(p0, p1, p2, p3, c, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_inrdy"}, 32'(in_ready), 32'd0);
        waitOutValid(n);
        checkOutput({tag, "_lat"}, 32'(n), 32'd4);
        checkOutput({tag, "_prod"}, 32'(product), 32'(expected));
        tick();
        checkOutput({tag, "_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic seen;
        logic [35:0] pps;
        logic [15:0] c;
        logic signed [7:0] aVec [5];
        logic signed [7:0] bVec [5];
        int prodInt;

        tick();
        tick();
        checkOutput("rst_inrdy", 32'(in_ready), 32'd1);
        checkOutput("rst_oval", 32'(out_valid), 32'd0);
        checkOutput("rst_prod", 32'(product), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        runTxn("ones", 9'h001, 9'h001, 9'h001, 9'h001, 16'h0000, 16'h0055);
        runTxn("allff", 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 16'h0000, 16'hA9AB);
        runTxn("wrap", 9'h001, 9'h000, 9'h000, 9'h000, 16'hFFFF, 16'h0000);

        // Output stall: held product must not react to new input data.
        out_ready = 1'b0;
        applyStimulus(9'h002, 9'h000, 9'h000, 9'h000, 16'h0100, 1'b1);
        tick();
        in_valid = 1'b0;
        waitOutValid(n);
        checkOutput("stall_lat", 32'(n), 32'd4);
        checkOutput("stall_prod0", 32'(product), 32'h0102);
        for (int i = 0; i < 10; i++) begin
            pp_bus   = {4'($urandom), $urandom};
            cor      = 16'($urandom);
            in_valid = 1'b1;
            tick();
            checkOutput("stall_oval", 32'(out_valid), 32'd1);
            checkOutput("stall_prod", 32'(product), 32'h0102);
            checkOutput("stall_inrdy", 32'(in_ready), 32'd0);
        end
        applyStimulus(9'h003, 9'h003, 9'h000, 9'h000, 16'h0000, 1'b1);
        out_ready = 1'b1;
        tick();
        checkOutput("release_oval", 32'(out_valid), 32'd0);
        checkOutput("release_inrdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("release_busy", 32'(busy), 32'd1);
        waitOutValid(n);
        checkOutput("release_lat", 32'(n), 32'd4);
        checkOutput("release_prod", 32'(product), 32'h000F);
        tick();

        // Reset in the second ACC cycle discards the transaction.
        applyStimulus(9'h001, 9'h001, 9'h001, 9'h001, 16'h0000, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_oval", 32'(out_valid), 32'd0);
        checkOutput("abort_inrdy", 32'(in_ready), 32'd1);
        checkOutput("abort_prod", 32'(product), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checkOutput("abort_nostale", 32'(seen), 32'd0);
        runTxn("postrst", 9'h010, 9'h020, 9'h000, 9'h000, 16'h1000, 16'h1090);

        // Back-to-back 8x8 signed products with in_valid held high.
        aVec[0] = 8'sd5;    bVec[0] = 8'sd7;
        aVec[1] = 8'sd127;  bVec[1] = -8'sd128;
        aVec[2] = -8'sd127; bVec[2] = -8'sd128;
        aVec[3] = -8'sd1;   bVec[3] = 8'sd1;
        aVec[4] = 8'sd100;  bVec[4] = -8'sd3;
        boothGen(aVec[0], bVec[0], pps, c);
        pp_bus   = pps;
        cor      = c;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("b2b_busy", 32'(busy), 32'd1);
            prodInt = int'(aVec[k]) * int'(bVec[k]);
            if (k < 4) begin
                boothGen(aVec[k+1], bVec[k+1], pps, c);
                pp_bus = pps;
                cor    = c;
            end
            waitOutValid(n);
            checkOutput("b2b_lat", 32'(n), 32'd4);
            checkOutput("b2b_prod", 32'(product), 32'(prodInt[15:0]));
            tick();
            checkOutput("b2b_inrdy", 32'(in_ready), 32'd1);
            checkOutput("b2b_oval", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
